htif_tohost_mon: RTL and testbench

- Passive AXI write-channel snooper on the DDR slave port (`axi_ddr`, between `cpu_wrap` and `u_ddr`).
- Decodes riscv-tests HTIF "tohost" mailbox writes into exit and putchar events in RTL, replacing behavioural polling of DDR memory.
- Never drives any AXI signal; only observes completed handshakes.
- Events feed the bench's simend and console logic.

---
 rtl/htif_tohost_mon.sv | 213 +++++++++++++++++++++
 tb/tb_htif_tohost_mon.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htif_tohost_mon.sv
// htif_tohost_mon: passive snooper for riscv-tests HTIF "tohost" mailbox
// writes on an AXI write port. Decodes exit and putchar commands and flags
// malformed write traffic. It never drives the bus.
// Optional feature: define HTIF_MON_BRESP_EN to hold each command until the
// matching B response and drop it on a non-OKAY response.
module htif_tohost_mon #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int          ID_W        = 6,
    parameter int          LEN_W       = 8,
    parameter int          AWQ_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             awvalid,
    input  logic             awready,
    input  logic [ID_W-1:0]  awid,
    input  logic [31:0]      awaddr,
    input  logic [LEN_W-1:0] awlen,
    input  logic [2:0]       awsize,
    input  logic [1:0]       awburst,
    input  logic             wvalid,
    input  logic             wready,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wlast,
    input  logic             bvalid,
    input  logic             bready,
    input  logic [ID_W-1:0]  bid,
    input  logic [1:0]       bresp,
    output logic             exit_vld,
    output logic [31:0]      exit_code,
    output logic             char_vld,
    output logic [7:0]       char_data,
    output logic             cmd_err,
    output logic             proto_err,
    output logic             busy
);
    localparam int          PTR_W    = (AWQ_DEPTH > 1) ? $clog2(AWQ_DEPTH) : 1;
    localparam logic [31:0] CHAR_CMD = 32'h0101_0000;
    localparam logic [29:0] LO_WADDR = TOHOST_ADDR[31:2];
    localparam logic [29:0] HI_WADDR = TOHOST_ADDR[31:2] + 30'd1;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } aw_t;

    aw_t              q_mem [AWQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [LEN_W-1:0] beat_reg;
    logic [31:0]      lo_reg, hi_reg;

    logic aw_hs, w_hs, b_hs, q_empty, q_full;
    aw_t  aw_in, head;
    logic beat_ok, w_orphan, last_beat, wlast_err, pop, bypass_done;
    logic push_req, push, overflow;
    logic [31:0] beat_off, wrap_mask, beat_addr;
    logic hit_lo, hit_hi, commit;
    logic [31:0] lo_merged, hi_merged;
    logic ev_fire, ev_nack, pend_err;
    logic [31:0] ev_lo, ev_hi;
    logic ev_is_exit, ev_is_char, ev_is_bad;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign b_hs    = bvalid & bready;
    assign q_empty = (count_reg == '0);
    assign q_full  = (count_reg == (PTR_W+1)'(AWQ_DEPTH));
    assign aw_in   = {awid, awaddr, awlen, awsize, awburst};

    // An empty queue lets a same-cycle AW feed the beat logic directly.
    assign head        = q_empty ? aw_in : q_mem[rd_ptr_reg];
    assign beat_ok     = w_hs & (~q_empty | aw_hs);
    assign w_orphan    = w_hs & q_empty & ~aw_hs;
    assign last_beat   = (beat_reg == head.len);
    assign wlast_err   = beat_ok & (wlast != last_beat);
    assign pop         = beat_ok & last_beat & ~q_empty;
    assign bypass_done = beat_ok & last_beat & q_empty;
    // A bypassed single-beat burst is finished already and never queued.
    assign push_req    = aw_hs & ~bypass_done;
    assign push        = push_req & (~q_full | pop);
    assign overflow    = push_req & q_full & ~pop;

    // Address of the current beat from the head burst descriptor
    always_comb begin
        beat_off  = 32'(beat_reg) << head.size;
        wrap_mask = ((32'(head.len) + 32'd1) << head.size) - 32'd1;
        case (head.burst)
            2'd0:    beat_addr = head.addr;
            2'd2:    beat_addr = (head.addr & ~wrap_mask) | ((head.addr + beat_off) & wrap_mask);
            default: beat_addr = head.addr + beat_off;
        endcase
    end

    assign hit_lo = beat_ok && (beat_addr[31:2] == LO_WADDR);
    assign hit_hi = beat_ok && (beat_addr[31:2] == HI_WADDR);
    assign commit = hit_hi;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign lo_merged[8*gi +: 8] = (hit_lo && wstrb[gi]) ? wdata[8*gi +: 8] : lo_reg[8*gi +: 8];
            assign hi_merged[8*gi +: 8] = (hit_hi && wstrb[gi]) ? wdata[8*gi +: 8] : hi_reg[8*gi +: 8];
        end
    endgenerate

`ifdef HTIF_MON_BRESP_EN
    logic            pend_vld_reg;
    logic [ID_W-1:0] pend_id_reg;
    logic [31:0]     pend_lo_reg, pend_hi_reg;
    logic            b_match, commit_nz;

    assign b_match   = b_hs && pend_vld_reg && (bid == pend_id_reg);
    assign commit_nz = commit && ({hi_merged, lo_merged} != 64'd0);
    assign ev_fire   = b_match && (bresp == 2'b00);
    assign ev_nack   = b_match && (bresp != 2'b00);
    assign ev_lo     = pend_lo_reg;
    assign ev_hi     = pend_hi_reg;
    // A response for the old command in the same cycle frees the slot cleanly.
    assign pend_err  = commit_nz && pend_vld_reg && !b_match;

    // Hold a committed command until its write response arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_reg <= 1'b0;
            pend_id_reg  <= '0;
            pend_lo_reg  <= '0;
            pend_hi_reg  <= '0;
        end else if (commit_nz) begin
            pend_vld_reg <= 1'b1;
            pend_id_reg  <= head.id;
            pend_lo_reg  <= lo_merged;
            pend_hi_reg  <= hi_merged;
        end else if (b_match) begin
            pend_vld_reg <= 1'b0;
        end
    end
`else
    logic unused_b;
    assign ev_fire  = commit;
    assign ev_nack  = 1'b0;
    assign ev_lo    = lo_merged;
    assign ev_hi    = hi_merged;
    assign pend_err = 1'b0;
    assign unused_b = ^{bvalid, bready, bid, bresp, b_hs, head.id};
`endif

    logic unused_lsb;
    assign unused_lsb = ^beat_addr[1:0];

    assign ev_is_exit = (ev_hi == 32'd0) && (ev_lo != 32'd0);
    assign ev_is_char = (ev_hi == CHAR_CMD);
    assign ev_is_bad  = (ev_hi != 32'd0) && !ev_is_char;

    // Descriptor storage; only the pointers need resetting
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr_reg] <= aw_in;
    end

    // Queue pointers, beat counter and mailbox shadow words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            beat_reg   <= '0;
            lo_reg     <= '0;
            hi_reg     <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (beat_ok) beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
            if (commit) begin
                lo_reg <= '0;
                hi_reg <= '0;
            end else begin
                lo_reg <= lo_merged;
                hi_reg <= hi_merged;
            end
        end
    end

    // Registered event pulses, held payloads and sticky protocol flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exit_vld  <= 1'b0;
            exit_code <= '0;
            char_vld  <= 1'b0;
            char_data <= '0;
            cmd_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            exit_vld  <= ev_fire && ev_is_exit;
            char_vld  <= ev_fire && ev_is_char;
            cmd_err   <= (ev_fire && ev_is_bad) || ev_nack;
            if (ev_fire && ev_is_exit) exit_code <= ev_lo;
            if (ev_fire && ev_is_char) char_data <= ev_lo[7:0];
            proto_err <= proto_err | w_orphan | overflow | wlast_err | pend_err;
        end
    end

    assign busy = ~q_empty | (beat_reg != '0);

endmodule

// File: tb/tb_htif_tohost_mon.sv
// tb_htif_tohost_mon: directed mailbox scenarios plus randomized AXI write
// traffic, checked every cycle against a queue-based model of the monitor.
module tb_htif_tohost_mon;
    localparam logic [31:0] T  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 0, awready = 1, wvalid = 0, wready = 1, wlast = 0;
    logic        bvalid = 0, bready = 1;
    logic [5:0]  awid = 0, bid = 0;
    logic [31:0] awaddr = 0, wdata = 0;
    logic [7:0]  awlen = 0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'd1, bresp = 0;
    logic [3:0]  wstrb = 0;
    logic        exit_vld, char_vld, cmd_err, proto_err, busy;
    logic [31:0] exit_code;
    logic [7:0]  char_data;

    int n_vec = 0;
    int n_mis = 0;

    htif_tohost_mon #(.TOHOST_ADDR(T), .ID_W(6), .LEN_W(8), .AWQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .exit_vld(exit_vld), .exit_code(exit_code), .char_vld(char_vld),
        .char_data(char_data), .cmd_err(cmd_err), .proto_err(proto_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned     id;
        longint unsigned addr;
        int unsigned     len;
        int unsigned     size;
        int unsigned     burst;
    } mburst_t;

    mburst_t     mq[$];
    int unsigned m_beat;
    logic [31:0] m_lo, m_hi;
    logic        e_exit_vld, e_char_vld, e_cmd_err, e_proto;
    logic [31:0] e_exit_code;
    logic [7:0]  e_char_data;
    logic        m_pend;
    int unsigned m_pend_id;
    logic [31:0] m_pend_lo, m_pend_hi;

    function automatic logic [31:0] m_addr(input mburst_t h, input int unsigned n);
        longint unsigned bytes, span, base, a;
        bytes = longint'(1) << h.size;
        if (h.burst == 0) a = h.addr;
        else if (h.burst == 2) begin
            span = (h.len + 1) * bytes;
            base = h.addr - (h.addr % span);
            a = base + ((h.addr % span) + n * bytes) % span;
        end else a = h.addr + n * bytes;
        return a[31:0];
    endfunction

    task automatic m_fire(input logic [31:0] lo, input logic [31:0] hi);
        if (hi == 0 && lo == 0) return;
        if (hi == 0) begin e_exit_vld = 1; e_exit_code = lo; end
        else if (hi == 32'h0101_0000) begin e_char_vld = 1; e_char_data = lo[7:0]; end
        else e_cmd_err = 1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_beat = 0; m_lo = 0; m_hi = 0; m_pend = 0; m_pend_id = 0; m_pend_lo = 0; m_pend_hi = 0;
        e_exit_vld = 0; e_char_vld = 0; e_cmd_err = 0; e_proto = 0; e_exit_code = 0; e_char_data = 0;
    endtask

    task automatic model_step();
        mburst_t     h, a_now;
        bit          have_h, consumed, has_cmd;
        logic [31:0] wa, c_lo, c_hi;
        e_exit_vld = 0; e_char_vld = 0; e_cmd_err = 0;
        a_now = '{awid, awaddr, awlen, awsize, awburst};
        have_h = 0; consumed = 0; has_cmd = 0; c_lo = 0; c_hi = 0;
        if (wvalid && wready) begin
            if (mq.size() > 0) begin h = mq[0]; have_h = 1; end
            else if (awvalid && awready) begin h = a_now; have_h = 1; end
            else e_proto = 1;
            if (have_h) begin
                if (wlast != (m_beat == h.len)) e_proto = 1;
                wa = m_addr(h, m_beat);
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b] && wa[31:2] == T[31:2]) m_lo[8*b +: 8] = wdata[8*b +: 8];
                    if (wstrb[b] && wa[31:2] == T[31:2] + 1) m_hi[8*b +: 8] = wdata[8*b +: 8];
                end
                if (wa[31:2] == T[31:2] + 1) begin
                    has_cmd = 1; c_lo = m_lo; c_hi = m_hi; m_lo = 0; m_hi = 0;
                end
                if (m_beat == h.len) begin
                    if (mq.size() > 0) void'(mq.pop_front()); else consumed = 1;
                    m_beat = 0;
                end else m_beat++;
            end
        end
`ifdef HTIF_MON_BRESP_EN
        if (bvalid && bready && m_pend && bid == m_pend_id) begin
            if (bresp == 0) m_fire(m_pend_lo, m_pend_hi); else e_cmd_err = 1;
            m_pend = 0;
        end
        if (has_cmd && {c_hi, c_lo} != 0) begin
            if (m_pend) e_proto = 1;
            m_pend = 1; m_pend_id = h.id; m_pend_lo = c_lo; m_pend_hi = c_hi;
        end
`else
        if (has_cmd) m_fire(c_lo, c_hi);
`endif
        if (awvalid && awready && !consumed) begin
            if (mq.size() < DEPTH) mq.push_back(a_now); else e_proto = 1;
        end
    endtask

    // Single compare process: model advances on each edge, outputs checked 1 time unit later
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset(); else model_step();
            #1;
            chk("exit_vld", 32'(exit_vld), 32'(e_exit_vld));
            chk("exit_code", exit_code, e_exit_code);
            chk("char_vld", 32'(char_vld), 32'(e_char_vld));
            chk("char_data", 32'(char_data), 32'(e_char_data));
            chk("cmd_err", 32'(cmd_err), 32'(e_cmd_err));
            chk("proto_err", 32'(proto_err), 32'(e_proto));
            chk("busy", 32'(busy), 32'((mq.size() != 0) || (m_beat != 0)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        awvalid = 0; wvalid = 0; wlast = 0; bvalid = 0;
        awready = 1; wready = 1; bready = 1;
    endtask

    task automatic set_aw(input logic [31:0] a, input int len, input int sz, input int bu, input int id);
        awvalid = 1; awready = 1; awaddr = a; awlen = 8'(len); awsize = 3'(sz); awburst = 2'(bu); awid = 6'(id);
    endtask

    task automatic set_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        wvalid = 1; wready = 1; wdata = d; wstrb = s; wlast = l;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int id);
        set_aw(a, 0, 2, 1, id); set_w(d, s, 1'b1); tick(); idle();
    endtask

    task automatic aw_only(input logic [31:0] a, input int len, input int bu, input int id);
        set_aw(a, len, 2, bu, id); tick(); idle();
    endtask

    task automatic w_only(input logic [31:0] d, input logic [3:0] s, input logic l);
        set_w(d, s, l); tick(); idle();
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'($urandom_range(1, 255));
            2:       return 32'h0101_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int cycles);
        logic [31:0] g_addr;
        int g_len, g_size, g_burst, g_id, w_len, wbeat;
        bit have, aw_fire;
        int wq[$];
        have = 0; wbeat = 0;
        for (int c = 0; c < cycles; c++) begin
            if (!have) begin
                case ($urandom_range(0, 5))
                    0: g_addr = T;
                    1: g_addr = T + 4;
                    2: g_addr = T - 4;
                    3: g_addr = T + 8;
                    4: g_addr = T - 8;
                    default: g_addr = $urandom & 32'hFFFF_FFFC;
                endcase
                g_burst = $urandom_range(0, 2);
                g_size  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 2;
                g_len   = (g_burst == 2) ? (($urandom_range(0, 1) == 1) ? 1 : 3) : $urandom_range(0, 3);
                g_id    = $urandom_range(0, 3);
                have    = 1;
            end
            awvalid = have && (wq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            awready = ($urandom_range(0, 3) != 0);
            awaddr = g_addr; awlen = 8'(g_len); awsize = 3'(g_size); awburst = 2'(g_burst); awid = 6'(g_id);
            aw_fire = awvalid && awready;
            w_len = (wq.size() > 0) ? wq[0] : (aw_fire ? g_len : -1);
            wvalid = (w_len >= 0) && ($urandom_range(0, 2) != 0);
            wready = ($urandom_range(0, 3) != 0);
            wdata  = pick_data();
            wstrb  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            wlast  = (w_len >= 0) && (wbeat == w_len);
            bvalid = ($urandom_range(0, 3) == 0);
            bready = 1;
            bid    = 6'($urandom_range(0, 3));
            bresp  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            tick();
            if (aw_fire) begin wq.push_back(g_len); have = 0; end
            if (wvalid && wready) begin
                if (wbeat == wq[0]) begin void'(wq.pop_front()); wbeat = 0; end
                else wbeat++;
            end
        end
        idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        rst = 1;
        tick(); tick();
        chk("rst_exit_code", exit_code, 32'h0);
        chk("rst_proto", 32'(proto_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 0;
        tick();

`ifdef HTIF_MON_BRESP_EN
        wr1(T, 32'h1, 4'hF, 5);
        wr1(T + 4, 32'h0, 4'hF, 5);
        chk("bresp_hold", 32'(exit_vld), 32'h0);
        bvalid = 1; bid = 6'd5; bresp = 2'b10; tick(); idle();
        chk("bresp_slverr_err", 32'(cmd_err), 32'h1);
        chk("bresp_slverr_noexit", 32'(exit_vld), 32'h0);
        wr1(T, 32'h1, 4'hF, 3);
        wr1(T + 4, 32'h0, 4'hF, 3);
        tick(); tick(); tick();
        chk("bresp_wait", 32'(exit_vld), 32'h0);
        bvalid = 1; bid = 6'd3; bresp = 2'b00; tick(); idle();
        chk("bresp_ok_exit", 32'(exit_vld), 32'h1);
        chk("bresp_ok_code", exit_code, 32'h1);
        wr1(T, 32'h2, 4'hF, 1); wr1(T + 4, 32'h0, 4'hF, 1);
        wr1(T, 32'h3, 4'hF, 1); wr1(T + 4, 32'h0, 4'hF, 1);
        chk("bresp_overwrite", 32'(proto_err), 32'h1);
        do_reset();
`else
        // exit via two single writes
        wr1(T, 32'h1, 4'hF, 1);
        chk("lo_no_event", 32'(exit_vld), 32'h0);
        wr1(T + 4, 32'h0, 4'hF, 1);
        chk("exit_pulse", 32'(exit_vld), 32'h1);
        chk("exit_code1", exit_code, 32'h1);
        wr1(T + 4, 32'h0, 4'hF, 1);
        chk("shadow_cleared", 32'(exit_vld), 32'h0);
        // putchar
        wr1(T, 32'h41, 4'hF, 2);
        wr1(T + 4, 32'h0101_0000, 4'hF, 2);
        chk("char_pulse", 32'(char_vld), 32'h1);
        chk("char_data", 32'(char_data), 32'h41);
        chk("char_no_exit", 32'(exit_vld), 32'h0);
        // INCR len=1 with the AW bypassing into the first beat
        set_aw(T, 1, 2, 1, 3); set_w(32'h2A, 4'hF, 1'b0); tick(); idle();
        chk("incr_busy", 32'(busy), 32'h1);
        w_only(32'h0, 4'hF, 1'b1);
        chk("incr_exit", 32'(exit_vld), 32'h1);
        chk("incr_code", exit_code, 32'h2A);
        // WRAP len=1 starting at the high word: hi beat then lo beat
        aw_only(T + 4, 1, 2, 4);
        w_only(32'h0, 4'hF, 1'b0);
        w_only(32'h5, 4'hF, 1'b1);
        chk("wrap_no_commit", 32'(exit_vld), 32'h0);
        wr1(T + 4, 32'h0, 4'hF, 4);
        chk("wrap_code", exit_code, 32'h5);
        // byte strobes
        wr1(T, 32'hDEAD_BEEF, 4'b0001, 0);
        wr1(T, 32'h1111_1111, 4'b0000, 0);
        wr1(T, 32'hDEAD_BEEF, 4'b0010, 0);
        wr1(T, 32'hDEAD_BEEF, 4'b0100, 0);
        wr1(T, 32'hDEAD_BEEF, 4'b1000, 0);
        wr1(T + 4, 32'h0, 4'hF, 0);
        chk("strb_code", exit_code, 32'hDEAD_BEEF);
        // unknown command
        wr1(T + 4, 32'h2, 4'hF, 0);
        chk("unknown_cmd_err", 32'(cmd_err), 32'h1);
        chk("unknown_no_exit", 32'(exit_vld), 32'h0);
        // AW queue overflow
        for (int i = 0; i < 4; i++) aw_only(32'h2000, 0, 1, i);
        chk("q4_no_err", 32'(proto_err), 32'h0);
        aw_only(32'h2000, 0, 1, 4);
        chk("q5_overflow", 32'(proto_err), 32'h1);
        // async reset clears everything at once
        rst = 1; #1;
        chk("arst_proto", 32'(proto_err), 32'h0);
        chk("arst_code", exit_code, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        tick(); rst = 0; tick();
        // reset in the middle of a burst discards its partial data
        set_aw(T, 3, 2, 1, 1); set_w(32'h55, 4'hF, 1'b0); tick(); idle();
        rst = 1; #1;
        chk("mid_busy", 32'(busy), 32'h0);
        tick(); rst = 0; tick();
        wr1(T + 4, 32'h0, 4'hF, 1);
        chk("mid_discard", 32'(exit_vld), 32'h0);
        wr1(T, 32'h7, 4'hF, 1);
        wr1(T + 4, 32'h0, 4'hF, 1);
        chk("post_rst_code", exit_code, 32'h7);
        // wlast mismatch and orphan W beat
        w_only(32'h0, 4'hF, 1'b1);
        chk("orphan_w", 32'(proto_err), 32'h1);
        do_reset();
        set_aw(32'h3000, 1, 2, 1, 1); set_w(32'h0, 4'hF, 1'b1); tick(); idle();
        chk("early_wlast", 32'(proto_err), 32'h1);
        w_only(32'h0, 4'hF, 1'b1);
        do_reset();
`endif

        random_phase(4000);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
